// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, default line rate and frame width.
package uart_pkg;

  // 50 MHz / 117647 baud, matching the on-board transmitter.
  localparam int DEFAULT_CLKS_PER_BIT = 425;
  localparam int DATA_BITS            = 8;

  // Receiver state encodings.
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_PARITY    = 3'd3;
  localparam logic [2:0] ST_STOP      = 3'd4;
  localparam logic [2:0] ST_CLEANUP   = 3'd5;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd6;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    START     = ST_START,
    DATA      = ST_DATA,
    PARITY    = ST_PARITY,
    STOP      = ST_STOP,
    CLEANUP   = ST_CLEANUP,
    WAIT_HIGH = ST_WAIT_HIGH
  } rx_state_t;

  // Even parity: the parity bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// N-stage synchronizer for an asynchronous pin; flops reset to 1 (idle-high line).
module uart_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic i_Clock,
  input  logic i_Rst_n,
  input  logic i_Async,
  output logic o_Sync
);

  logic [STAGES-1:0] sync_reg;

  // Shift the async input through the flop chain; reset presents an idle line.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      sync_reg <= '1;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], i_Async};
    end
  end

  assign o_Sync = sync_reg[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 by default; define UART_RX_PARITY_EN for 8E1 with a parity-error strobe.
// Each bit is sampled at its mid-point; good bytes are presented with a one-cycle o_Rx_DV strobe.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_n,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Rx_Active,
  output logic                 o_Frame_Err,
  output logic                 o_Parity_Err
);

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

  logic rx_s;

  rx_state_t              state_reg,   state_next;
  logic [CNT_W-1:0]       cnt_reg,     cnt_next;
  logic [2:0]             bit_idx_reg, bit_idx_next;
  logic [DATA_BITS-1:0]   shift_reg,   shift_next;
  logic [DATA_BITS-1:0]   byte_reg,    byte_next;
  logic                   dv_reg,      dv_next;
  logic                   ferr_reg,    ferr_next;
  logic                   active_reg,  active_next;
`ifdef UART_RX_PARITY_EN
  logic                   perr_reg,    perr_next;
  logic                   par_bad_reg, par_bad_next;
`endif

  uart_rx_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .i_Clock (i_Clock),
    .i_Rst_n (i_Rst_n),
    .i_Async (i_Rx_Serial),
    .o_Sync  (rx_s)
  );

  // Register all FSM state, counters and output flops; reset aborts any frame in flight.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      byte_reg    <= '0;
      dv_reg      <= 1'b0;
      ferr_reg    <= 1'b0;
      active_reg  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_reg    <= 1'b0;
      par_bad_reg <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
      byte_reg    <= byte_next;
      dv_reg      <= dv_next;
      ferr_reg    <= ferr_next;
      active_reg  <= active_next;
`ifdef UART_RX_PARITY_EN
      perr_reg    <= perr_next;
      par_bad_reg <= par_bad_next;
`endif
    end
  end

  // Next-state logic: strobes default low so they can never last more than one cycle.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    byte_next    = byte_reg;
    dv_next      = 1'b0;
    ferr_next    = 1'b0;
    active_next  = active_reg;
`ifdef UART_RX_PARITY_EN
    perr_next    = 1'b0;
    par_bad_next = par_bad_reg;
`endif
    case (state_reg)
      IDLE: begin
        cnt_next     = '0;
        bit_idx_next = '0;
`ifdef UART_RX_PARITY_EN
        par_bad_next = 1'b0;
`endif
        if (!rx_s) begin
          state_next  = START;
          active_next = 1'b1;
        end
      end
      START: begin
        if (cnt_reg == CNT_MID) begin
          cnt_next = '0;
          if (!rx_s) begin
            state_next = DATA;
          end else begin
            // Line went back high before mid-bit: treat as a glitch.
            state_next  = IDLE;
            active_next = 1'b0;
          end
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      DATA: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next                = '0;
          shift_next[bit_idx_reg] = rx_s;
          if (bit_idx_reg == IDX_LAST) begin
            bit_idx_next = '0;
`ifdef UART_RX_PARITY_EN
            state_next   = PARITY;
`else
            state_next   = STOP;
`endif
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next     = '0;
          par_bad_next = (rx_s != even_parity(shift_reg));
          state_next   = STOP;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
`endif
      STOP: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next = '0;
          if (!rx_s) begin
            // Framing error wins over any parity error; wait for the line to recover.
            ferr_next  = 1'b1;
            state_next = WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
          end else if (par_bad_reg) begin
            perr_next  = 1'b1;
            state_next = CLEANUP;
`endif
          end else begin
            byte_next  = shift_reg;
            dv_next    = 1'b1;
            state_next = CLEANUP;
          end
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      CLEANUP: begin
        state_next  = IDLE;
        active_next = 1'b0;
      end
      WAIT_HIGH: begin
        if (rx_s) begin
          state_next  = IDLE;
          active_next = 1'b0;
        end
      end
      default: begin
        state_next  = IDLE;
        cnt_next    = '0;
        active_next = 1'b0;
      end
    endcase
  end

  assign o_Rx_DV     = dv_reg;
  assign o_Rx_Byte   = byte_reg;
  assign o_Rx_Active = active_reg;
  assign o_Frame_Err = ferr_reg;
`ifdef UART_RX_PARITY_EN
  assign o_Parity_Err = perr_reg;
`else
  assign o_Parity_Err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx; honours UART_RX_PARITY_EN for the 8E1 build.
module tb_uart_rx;

  localparam int CPB = 87;
  localparam int MID = (CPB - 1) / 2;
`ifdef UART_RX_PARITY_EN
  localparam int SAMPLE_BITS = 10;
`else
  localparam int SAMPLE_BITS = 9;
`endif
  // start-detect (2 sync + 1 FSM) + half start bit + 1 + data/parity/stop periods
  localparam int EXP_LATENCY = 3 + MID + 1 + SAMPLE_BITS * CPB;

  logic       i_Clock = 1'b0;
  logic       i_Rst_n = 1'b0;
  logic       i_Rx_Serial = 1'b1;
  logic       o_Rx_DV;
  logic [7:0] o_Rx_Byte;
  logic       o_Rx_Active;
  logic       o_Frame_Err;
  logic       o_Parity_Err;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int dv_cnt = 0;
  int fe_cnt = 0;
  int pe_cnt = 0;
  int viol_cnt = 0;
  int last_dv_cyc = 0;
  logic dv_prev = 1'b0;
  logic fe_prev = 1'b0;
  logic pe_prev = 1'b0;
  logic [7:0] rx_q[$];

  uart_rx #(
    .CLKS_PER_BIT (CPB),
    .SYNC_STAGES  (2)
  ) dut (
    .i_Clock      (i_Clock),
    .i_Rst_n      (i_Rst_n),
    .i_Rx_Serial  (i_Rx_Serial),
    .o_Rx_DV      (o_Rx_DV),
    .o_Rx_Byte    (o_Rx_Byte),
    .o_Rx_Active  (o_Rx_Active),
    .o_Frame_Err  (o_Frame_Err),
    .o_Parity_Err (o_Parity_Err)
  );

  always #10 i_Clock = ~i_Clock;

  always @(posedge i_Clock) cyc <= cyc + 1;

  // Strobe monitor, sampled on the falling edge.
  always @(negedge i_Clock) begin
    if (o_Rx_DV === 1'b1) begin
      dv_cnt      <= dv_cnt + 1;
      last_dv_cyc <= cyc;
      rx_q.push_back(o_Rx_Byte);
      $display("[TB] rx byte 0x%02h at cycle %0d", o_Rx_Byte, cyc);
    end
    if (o_Frame_Err === 1'b1) begin
      fe_cnt <= fe_cnt + 1;
      $display("[TB] frame-error strobe at cycle %0d", cyc);
    end
    if (o_Parity_Err === 1'b1) begin
      pe_cnt <= pe_cnt + 1;
      $display("[TB] parity-error strobe at cycle %0d", cyc);
    end
    if ((int'(o_Rx_DV === 1'b1) + int'(o_Frame_Err === 1'b1) + int'(o_Parity_Err === 1'b1) > 1) ||
        (o_Rx_DV === 1'b1 && dv_prev) || (o_Frame_Err === 1'b1 && fe_prev) ||
        (o_Parity_Err === 1'b1 && pe_prev))
      viol_cnt <= viol_cnt + 1;
    dv_prev <= (o_Rx_DV === 1'b1);
    fe_prev <= (o_Frame_Err === 1'b1);
    pe_prev <= (o_Parity_Err === 1'b1);
  end

  task automatic drive_bit(input logic v);
    i_Rx_Serial = v;
    repeat (CPB) @(negedge i_Clock);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_bad);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ par_bad);
`else
    if (par_bad) $display("[TB] parity flag ignored in 8N1 build");
`endif
    drive_bit(stop_v);
  endtask

  task automatic test_reset();
    i_Rst_n = 1'b0;
    repeat (3) @(negedge i_Clock);
    tests_run++; if (o_Rx_DV !== 1'b0) begin tests_failed++; $display("FAIL reset_dv: got %b want 0", o_Rx_DV); end
    tests_run++; if (o_Rx_Byte !== 8'h00) begin tests_failed++; $display("FAIL reset_byte: got %h want 00", o_Rx_Byte); end
    tests_run++; if (o_Rx_Active !== 1'b0) begin tests_failed++; $display("FAIL reset_active: got %b want 0", o_Rx_Active); end
    tests_run++; if (o_Frame_Err !== 1'b0) begin tests_failed++; $display("FAIL reset_ferr: got %b want 0", o_Frame_Err); end
    tests_run++; if (o_Parity_Err !== 1'b0) begin tests_failed++; $display("FAIL reset_perr: got %b want 0", o_Parity_Err); end
    i_Rst_n = 1'b1;
    repeat (5) @(negedge i_Clock);
  endtask

  task automatic test_single_byte();
    int dv0 = dv_cnt;
    int fe0 = fe_cnt;
    int pe0 = pe_cnt;
    int c0 = cyc;
    send_frame(8'h41, 1'b1, 1'b0);
    repeat (4) @(negedge i_Clock);
    tests_run++; if (dv_cnt - dv0 !== 1) begin tests_failed++; $display("FAIL single_dv_count: got %0d want 1", dv_cnt - dv0); end
    tests_run++; if (o_Rx_Byte !== 8'h41) begin tests_failed++; $display("FAIL single_byte: got %h want 41", o_Rx_Byte); end
    tests_run++; if ((fe_cnt - fe0) + (pe_cnt - pe0) !== 0) begin tests_failed++; $display("FAIL single_err: got %0d error strobes want 0", (fe_cnt - fe0) + (pe_cnt - pe0)); end
    tests_run++; if (o_Rx_Active !== 1'b0) begin tests_failed++; $display("FAIL single_active: got %b want 0", o_Rx_Active); end
    tests_run++; if (last_dv_cyc - c0 !== EXP_LATENCY) begin tests_failed++; $display("FAIL single_latency: got %0d want %0d", last_dv_cyc - c0, EXP_LATENCY); end
  endtask

  task automatic test_glitch();
    int dv0 = dv_cnt;
    int fe0 = fe_cnt;
    int pe0 = pe_cnt;
    int k = 20;
    i_Rx_Serial = 1'b0;
    repeat (20) @(negedge i_Clock);
    i_Rx_Serial = 1'b1;
    tests_run++; if (o_Rx_Active !== 1'b1) begin tests_failed++; $display("FAIL glitch_active_rise: got %b want 1", o_Rx_Active); end
    while (o_Rx_Active === 1'b1 && k < MID + 8) begin
      @(negedge i_Clock);
      k++;
    end
    tests_run++; if (o_Rx_Active !== 1'b0) begin tests_failed++; $display("FAIL glitch_active_drop: got %b want 0 after %0d clocks", o_Rx_Active, k); end
    repeat (CPB) @(negedge i_Clock);
    tests_run++; if ((dv_cnt - dv0) + (fe_cnt - fe0) + (pe_cnt - pe0) !== 0) begin tests_failed++; $display("FAIL glitch_strobes: got %0d strobes want 0", (dv_cnt - dv0) + (fe_cnt - fe0) + (pe_cnt - pe0)); end
    send_frame(8'h55, 1'b1, 1'b0);
    repeat (4) @(negedge i_Clock);
    tests_run++; if (dv_cnt - dv0 !== 1) begin tests_failed++; $display("FAIL glitch_next_dv: got %0d want 1", dv_cnt - dv0); end
    tests_run++; if (o_Rx_Byte !== 8'h55) begin tests_failed++; $display("FAIL glitch_next_byte: got %h want 55", o_Rx_Byte); end
  endtask

  task automatic test_frame_error();
    int dv0 = dv_cnt;
    int fe0 = fe_cnt;
    send_frame(8'hA5, 1'b0, 1'b0);
    repeat (3 * CPB) @(negedge i_Clock);
    tests_run++; if (fe_cnt - fe0 !== 1) begin tests_failed++; $display("FAIL ferr_count: got %0d want 1", fe_cnt - fe0); end
    tests_run++; if (dv_cnt - dv0 !== 0) begin tests_failed++; $display("FAIL ferr_dv: got %0d want 0", dv_cnt - dv0); end
    tests_run++; if (o_Rx_Byte !== 8'h55) begin tests_failed++; $display("FAIL ferr_byte_held: got %h want 55", o_Rx_Byte); end
    tests_run++; if (o_Rx_Active !== 1'b1) begin tests_failed++; $display("FAIL ferr_active_held: got %b want 1", o_Rx_Active); end
    i_Rx_Serial = 1'b1;
    repeat (6) @(negedge i_Clock);
    tests_run++; if (o_Rx_Active !== 1'b0) begin tests_failed++; $display("FAIL ferr_active_release: got %b want 0", o_Rx_Active); end
    repeat (2 * CPB) @(negedge i_Clock);
    tests_run++; if ((dv_cnt - dv0) + (fe_cnt - fe0) !== 1) begin tests_failed++; $display("FAIL ferr_no_second_frame: got %0d strobes want 1", (dv_cnt - dv0) + (fe_cnt - fe0)); end
  endtask

  task automatic test_back_to_back();
    string s = "AT+SEND=0,5,AMOGH";
    int dv0 = dv_cnt;
    int fe0 = fe_cnt;
    int pe0 = pe_cnt;
    int base = rx_q.size();
    for (int i = 0; i < s.len(); i++) send_frame(s[i], 1'b1, 1'b0);
    repeat (4) @(negedge i_Clock);
    tests_run++; if (dv_cnt - dv0 !== 17) begin tests_failed++; $display("FAIL b2b_count: got %0d want 17", dv_cnt - dv0); end
    tests_run++; if ((fe_cnt - fe0) + (pe_cnt - pe0) !== 0) begin tests_failed++; $display("FAIL b2b_err: got %0d error strobes want 0", (fe_cnt - fe0) + (pe_cnt - pe0)); end
    if (rx_q.size() >= base + s.len()) begin
      for (int i = 0; i < s.len(); i++) begin
        tests_run++;
        if (rx_q[base + i] !== s[i]) begin tests_failed++; $display("FAIL b2b_byte[%0d]: got %h want %h", i, rx_q[base + i], s[i]); end
      end
    end
  endtask

  task automatic test_reset_midframe();
    int dv0 = dv_cnt;
    int fe0 = fe_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    i_Rx_Serial = 1'b1;
    repeat (MID) @(negedge i_Clock);
    i_Rst_n = 1'b0;
    repeat (2) @(negedge i_Clock);
    tests_run++; if (o_Rx_DV !== 1'b0) begin tests_failed++; $display("FAIL midrst_dv: got %b want 0", o_Rx_DV); end
    tests_run++; if (o_Rx_Byte !== 8'h00) begin tests_failed++; $display("FAIL midrst_byte: got %h want 00", o_Rx_Byte); end
    tests_run++; if (o_Rx_Active !== 1'b0) begin tests_failed++; $display("FAIL midrst_active: got %b want 0", o_Rx_Active); end
    tests_run++; if (o_Frame_Err !== 1'b0 || o_Parity_Err !== 1'b0) begin tests_failed++; $display("FAIL midrst_err: got %b%b want 00", o_Frame_Err, o_Parity_Err); end
    i_Rst_n = 1'b1;
    repeat (6 * CPB) @(negedge i_Clock);
    tests_run++; if ((dv_cnt - dv0) + (fe_cnt - fe0) !== 0) begin tests_failed++; $display("FAIL midrst_no_strobe: got %0d want 0", (dv_cnt - dv0) + (fe_cnt - fe0)); end
    send_frame(8'h0F, 1'b1, 1'b0);
    repeat (4) @(negedge i_Clock);
    tests_run++; if (dv_cnt - dv0 !== 1) begin tests_failed++; $display("FAIL midrst_next_dv: got %0d want 1", dv_cnt - dv0); end
    tests_run++; if (o_Rx_Byte !== 8'h0F) begin tests_failed++; $display("FAIL midrst_next_byte: got %h want 0F", o_Rx_Byte); end
  endtask

  task automatic test_parity();
    int dv0 = dv_cnt;
    int pe0 = pe_cnt;
`ifdef UART_RX_PARITY_EN
    send_frame(8'h03, 1'b1, 1'b1);
    repeat (4) @(negedge i_Clock);
    tests_run++; if (pe_cnt - pe0 !== 1) begin tests_failed++; $display("FAIL parity_err_count: got %0d want 1", pe_cnt - pe0); end
    tests_run++; if (dv_cnt - dv0 !== 0) begin tests_failed++; $display("FAIL parity_err_dv: got %0d want 0", dv_cnt - dv0); end
    tests_run++; if (o_Rx_Byte !== 8'h0F) begin tests_failed++; $display("FAIL parity_err_byte_held: got %h want 0F", o_Rx_Byte); end
    send_frame(8'h03, 1'b1, 1'b0);
    repeat (4) @(negedge i_Clock);
    tests_run++; if (dv_cnt - dv0 !== 1) begin tests_failed++; $display("FAIL parity_ok_dv: got %0d want 1", dv_cnt - dv0); end
    tests_run++; if (o_Rx_Byte !== 8'h03) begin tests_failed++; $display("FAIL parity_ok_byte: got %h want 03", o_Rx_Byte); end
    tests_run++; if (pe_cnt - pe0 !== 1) begin tests_failed++; $display("FAIL parity_ok_no_err: got %0d want 1", pe_cnt - pe0); end
`else
    send_frame(8'h03, 1'b1, 1'b0);
    repeat (4) @(negedge i_Clock);
    tests_run++; if (dv_cnt - dv0 !== 1) begin tests_failed++; $display("FAIL nopar_dv: got %0d want 1", dv_cnt - dv0); end
    tests_run++; if (o_Rx_Byte !== 8'h03) begin tests_failed++; $display("FAIL nopar_byte: got %h want 03", o_Rx_Byte); end
    tests_run++; if (pe_cnt !== 0 || pe0 !== 0) begin tests_failed++; $display("FAIL nopar_perr: got %0d strobes want 0", pe_cnt); end
`endif
  endtask

  task automatic test_strobe_rules();
    tests_run++;
    if (viol_cnt !== 0) begin tests_failed++; $display("FAIL strobe_rules: got %0d overlapping/held strobes want 0", viol_cnt); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_glitch();
    test_frame_error();
    test_back_to_back();
    test_reset_midframe();
    test_parity();
    test_strobe_rules();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
